// File: rtl/framebuffer_reader_if.sv
// Pixel stream from the framebuffer scan-out engine to the video output stage.
interface framebuffer_reader_if #(
  parameter int unsigned DataWidth = 8
);
  logic [DataWidth-1:0] pix_data;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_sof;
  logic                 pix_eol;

  modport master (output pix_data, pix_valid, pix_sof, pix_eol, input pix_ready);
  modport slave  (input pix_data, pix_valid, pix_sof, pix_eol, output pix_ready);
endinterface

// File: rtl/framebuffer_reader.sv
// Raster scan-out engine: linear BRAM reads, read-latency absorption and a credit-limited
// pixel FIFO feeding a valid/ready stream with start-of-frame and end-of-line markers.
module framebuffer_reader #(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned FBUF_DATA_WIDTH = 8,
  parameter int unsigned H_RES           = 640,
  parameter int unsigned V_RES           = 480,
  parameter int unsigned BRAM_LATENCY    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  output logic                       fbuf_en_rd_o,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr_o,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_data_i,
  framebuffer_reader_if.master       m_pix,
  output logic                       frame_done_o,
  output logic                       busy_o
);

  localparam int unsigned Depth = BRAM_LATENCY + 2;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam logic [FBUF_ADDR_WIDTH-1:0] LastAddr = FBUF_ADDR_WIDTH'(H_RES * V_RES - 1);
  localparam logic [XW-1:0]              LastX    = XW'(H_RES - 1);
  localparam logic [PtrW-1:0]            LastPtr  = PtrW'(Depth - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  typedef struct packed {
    logic sof;
    logic eol;
    logic last;
  } tag_t;

  state_e                     state_q, state_d;
  logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XW-1:0]              x_q, x_d;
  logic                       issue;
  tag_t                       issue_tag;
  logic                       rd_q;
  logic [FBUF_ADDR_WIDTH-1:0] rd_addr_q;
  tag_t                       rd_tag_q;
  logic [BRAM_LATENCY-1:0]    pipe_vld_q;
  tag_t                       pipe_tag_q [BRAM_LATENCY];
  logic [FBUF_DATA_WIDTH-1:0] fifo_data_q [Depth];
  tag_t                       fifo_tag_q [Depth];
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            fifo_cnt_q;
  logic                       push, pop, fifo_valid;
  tag_t                       head_tag;
  int unsigned                occupancy;

  assign fifo_valid = (fifo_cnt_q != '0);
  assign head_tag   = fifo_tag_q[rd_ptr_q];
  assign push       = pipe_vld_q[BRAM_LATENCY-1];
  assign pop        = fifo_valid && m_pix.pix_ready;

  // Every read is counted from the issue register until it leaves the FIFO head; a pixel
  // leaving this cycle frees its slot at once so a continuously ready sink sees no bubbles.
  always_comb begin
    occupancy = 32'(rd_q) + 32'(fifo_cnt_q);
    for (int i = 0; i < BRAM_LATENCY; i++) occupancy += 32'(pipe_vld_q[i]);
    if (pop) occupancy -= 1;
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    x_d           = x_q;
    issue         = 1'b0;
    issue_tag.sof  = (addr_q == '0);
    issue_tag.eol  = (x_q == LastX);
    issue_tag.last = (addr_q == LastAddr);
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StRun;
          addr_d  = '0;
          x_d     = '0;
        end
      end
      StRun: begin
        if (occupancy < Depth) begin
          issue = 1'b1;
          x_d   = (x_q == LastX) ? '0 : x_q + XW'(1);
          if (addr_q == LastAddr) begin
            addr_d = '0;
            if (!enable_i) state_d = StDrain;
          end else begin
            addr_d = addr_q + FBUF_ADDR_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        if (pop && head_tag.last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      x_q        <= '0;
      rd_q       <= 1'b0;
      rd_addr_q  <= '0;
      rd_tag_q   <= '0;
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      rd_q    <= issue;
      if (issue) begin
        rd_addr_q <= addr_q;
        rd_tag_q  <= issue_tag;
      end
      pipe_vld_q[0] <= rd_q;
      for (int i = 1; i < BRAM_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  // Tag and data storage need no reset: only slots marked valid are ever observed.
  always_ff @(posedge clk_i) begin
    pipe_tag_q[0] <= rd_tag_q;
    for (int i = 1; i < BRAM_LATENCY; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
    if (push) begin
      fifo_data_q[wr_ptr_q] <= fbuf_data_i;
      fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[BRAM_LATENCY-1];
    end
  end

  assign fbuf_en_rd_o    = rd_q;
  assign fbuf_addr_o     = rd_addr_q;
  assign m_pix.pix_valid = fifo_valid;
  assign m_pix.pix_data  = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_pix.pix_sof   = fifo_valid && head_tag.sof;
  assign m_pix.pix_eol   = fifo_valid && head_tag.eol;
  assign frame_done_o    = pop && head_tag.last;
  assign busy_o          = (state_q != StIdle);

endmodule
